load_store_unit: RTL and testbench

- Memory-access stage of the pipeline; sits directly upstream of the byte-addressed data memory and drives its port.
- Turns MEM-stage load/store requests (RISC-V funct3 encoding) into memory address, write mask, write data and read handshake.
- Sign- or zero-extends returned load data and stalls the pipeline while a load is outstanding.

---
 rtl/load_store_unit.sv | 160 ++++++++++++++++
 tb/tb_load_store_unit.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Memory-access stage: turns MEM-stage load/store requests into data-memory port traffic and extends returned load data.
// Optional macro LSU_MISALIGN_TRAP_EN: when defined, misaligned halfword/word accesses raise access_fault.
module load_store_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_is_load,
  input  logic                  req_is_store,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_store_data,
  output logic                  stall,
  output logic                  load_data_valid,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic                  access_fault,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_write_enable,
  output logic [3:0]            mem_write_mask,
  output logic                  mem_read_enable,
  input  logic                  mem_read_valid,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_CAPT, RD_DONE} state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [2:0]            funct3_q;
  logic [DATA_WIDTH-1:0] load_data_q, load_data_d;
  logic                  load_data_valid_q;
  logic                  access_fault_q;

  logic in_idle, req_load, req_store, ld_f3_ok, st_f3_ok, misaligned;
  logic load_ok, store_ok, illegal;

  // Holding in_idle low during reset keeps every memory strobe at zero while rst is high.
  assign in_idle   = (state_q == IDLE) && !rst;
  assign req_load  = in_idle && req_valid && req_is_load && !req_is_store;
  assign req_store = in_idle && req_valid && req_is_store && !req_is_load;

  always_comb begin
    ld_f3_ok = 1'b0;
    st_f3_ok = 1'b0;
    case (req_funct3)
      F3_B, F3_H, F3_W: begin
        ld_f3_ok = 1'b1;
        st_f3_ok = 1'b1;
      end
      F3_BU, F3_HU: ld_f3_ok = 1'b1;
      default: ;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign load_ok  = req_load && ld_f3_ok && !misaligned;
  assign store_ok = req_store && st_f3_ok && !misaligned;
  assign illegal  = in_idle && req_valid &&
                    ((req_is_load && req_is_store) || (req_load && !load_ok) || (req_store && !store_ok));

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load_ok) state_d = RD_WAIT;
      RD_WAIT: if (mem_read_valid) state_d = RD_CAPT;
      RD_CAPT: state_d = RD_DONE;
      RD_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    // NOTE: every output gets a default first, so no path through the case infers a latch.
    stall            = 1'b0;
    mem_address      = '0;
    mem_write_data   = '0;
    mem_write_enable = 1'b0;
    mem_write_mask   = 4'b0000;
    mem_read_enable  = 1'b0;
    case (state_q)
      IDLE: begin
        if (store_ok) begin
          mem_address      = req_addr;
          mem_write_data   = req_store_data;
          mem_write_enable = 1'b1;
          case (req_funct3[1:0])
            2'b00:   mem_write_mask = 4'b0001;
            2'b01:   mem_write_mask = 4'b0011;
            default: mem_write_mask = 4'b1111;
          endcase
        end
        stall = load_ok;
      end
      RD_WAIT: begin
        mem_address     = addr_q;
        mem_read_enable = !mem_read_valid;
        stall           = 1'b1;
      end
      RD_CAPT: begin
        mem_address = addr_q;
        stall       = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (funct3_q)
      F3_B:    load_data_d = {{24{mem_read_data[7]}}, mem_read_data[7:0]};
      F3_H:    load_data_d = {{16{mem_read_data[15]}}, mem_read_data[15:0]};
      F3_BU:   load_data_d = {24'b0, mem_read_data[7:0]};
      F3_HU:   load_data_d = {16'b0, mem_read_data[15:0]};
      default: load_data_d = mem_read_data;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q            <= '0;
      funct3_q          <= '0;
      load_data_q       <= '0;
      load_data_valid_q <= 1'b0;
      access_fault_q    <= 1'b0;
    end else begin
      if (load_ok) begin
        addr_q   <= req_addr;
        funct3_q <= req_funct3;
      end
      if (state_q == RD_CAPT) load_data_q <= load_data_d;
      load_data_valid_q <= (state_q == RD_CAPT);
      access_fault_q    <= illegal;
    end
  end

  assign load_data       = load_data_q;
  assign load_data_valid = load_data_valid_q;
  assign access_fault    = access_fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: vector table plus scoreboard, with a byte memory model of adjustable ack delay.
module tb_load_store_unit;

  logic        clk, rst;
  logic        req_valid, req_is_load, req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_store_data;
  logic        stall, load_data_valid, access_fault;
  logic [31:0] load_data, mem_address, mem_write_data, mem_read_data;
  logic        mem_write_enable, mem_read_enable, mem_read_valid;
  logic [3:0]  mem_write_mask;

  load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_is_load(req_is_load), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_store_data(req_store_data),
    .stall(stall), .load_data_valid(load_data_valid), .load_data(load_data),
    .access_fault(access_fault), .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write_enable(mem_write_enable), .mem_write_mask(mem_write_mask),
    .mem_read_enable(mem_read_enable), .mem_read_valid(mem_read_valid),
    .mem_read_data(mem_read_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Byte memory model: acks after ack_delay cycles of read_enable, data follows one cycle later.
  logic [7:0]  mem [0:255];
  int          ack_delay = 1;
  int          ack_cnt = 0;
  logic        inject_ack = 1'b0;
  logic        nxt_valid;
  logic [31:0] nxt_data;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem_read_valid = 1'b0;
    mem_read_data  = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk);
      nxt_valid = 1'b0;
      nxt_data  = 32'hDEAD_BEEF;
      if (rst) begin
        ack_cnt = 0;
      end else begin
        if (mem_write_enable)
          for (int b = 0; b < 4; b++)
            if (mem_write_mask[b]) mem[8'(mem_address[7:0] + 8'(b))] = mem_write_data[8*b +: 8];
        if (mem_read_valid) begin
          for (int b = 0; b < 4; b++) nxt_data[8*b +: 8] = mem[8'(mem_address[7:0] + 8'(b))];
        end else if (mem_read_enable) begin
          ack_cnt++;
          if (ack_cnt >= ack_delay) begin
            nxt_valid = 1'b1;
            ack_cnt   = 0;
          end
        end
      end
      if (inject_ack) nxt_valid = 1'b1;
      @(posedge clk);
      #1;
      mem_read_valid = nxt_valid;
      mem_read_data  = nxt_data;
    end
  end

  // Scoreboard: each expected response (load data or fault pulse) is queued at request time.
  typedef struct packed {
    logic        fault;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (load_data_valid || access_fault)) begin
        if (sb.size() == 0) begin
          check("spurious load_data_valid", load_data_valid, 0);
          check("spurious access_fault", access_fault, 0);
        end else begin
          e = sb.pop_front();
          check("response access_fault", access_fault, e.fault);
          check("response load_data_valid", load_data_valid, !e.fault);
          if (!e.fault) check("response load_data", load_data, e.data);
        end
      end
    end
  end

  typedef enum logic [1:0] {K_STORE, K_LOAD, K_FAULT, K_NOP} kind_e;
  typedef struct packed {
    kind_e       kind;
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [3:0]  mask;
    logic [31:0] exp;
  } vec_t;

  function automatic vec_t mk(kind_e k, logic ld, logic st, logic [2:0] f3, logic [31:0] a,
                              logic [31:0] sd, logic [3:0] m, logic [31:0] e);
    vec_t v;
    v.kind = k; v.ld = ld; v.st = st; v.f3 = f3; v.addr = a; v.sdata = sd; v.mask = m; v.exp = e;
    return v;
  endfunction

  task automatic drive_req(input logic ld, input logic st, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] sd);
    @(posedge clk);
    #1;
    req_valid = 1'b1; req_is_load = ld; req_is_store = st;
    req_funct3 = f3; req_addr = a; req_store_data = sd;
  endtask

  task automatic idle(input int n);
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_is_load = 1'b0; req_is_store = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  task automatic do_req(input vec_t v);
    int lat;
    drive_req(v.ld, v.st, v.f3, v.addr, v.sdata);
    @(negedge clk);
    case (v.kind)
      K_STORE: begin
        check("store write_enable", mem_write_enable, 1);
        check("store mask", mem_write_mask, v.mask);
        check("store address", mem_address, v.addr);
        check("store write_data", mem_write_data, v.sdata);
        check("store stall", stall, 0);
      end
      K_LOAD: begin
        check("load accept stall", stall, 1);
        check("load accept write_enable", mem_write_enable, 0);
        sb.push_back('{fault: 1'b0, data: v.exp});
        for (lat = 1; lat <= 100; lat++) begin
          @(negedge clk);
          if (load_data_valid) break;
        end
        check("load latency", lat, 4);
      end
      default: begin
        check("no-access stall", stall, 0);
        check("no-access write_enable", mem_write_enable, 0);
        check("no-access read_enable", mem_read_enable, 0);
        if (v.kind == K_FAULT) sb.push_back('{fault: 1'b1, data: 32'h0});
      end
    endcase
    idle(2);
  endtask

  vec_t vecs[$];

  initial begin
    int   lat;
    logic saw;
    vecs.push_back(mk(K_STORE, 0, 1, 3'b000, 32'h10, 32'hAABB_CCDD, 4'b0001, 32'h0));
    vecs.push_back(mk(K_LOAD,  1, 0, 3'b100, 32'h10, 32'h0, 4'b0, 32'h0000_00DD));
    vecs.push_back(mk(K_STORE, 0, 1, 3'b010, 32'h20, 32'h80F0_1234, 4'b1111, 32'h0));
    vecs.push_back(mk(K_LOAD,  1, 0, 3'b000, 32'h23, 32'h0, 4'b0, 32'hFFFF_FF80));
    vecs.push_back(mk(K_LOAD,  1, 0, 3'b101, 32'h22, 32'h0, 4'b0, 32'h0000_80F0));
    vecs.push_back(mk(K_LOAD,  1, 0, 3'b010, 32'h20, 32'h0, 4'b0, 32'h80F0_1234));
    vecs.push_back(mk(K_LOAD,  1, 0, 3'b001, 32'h22, 32'h0, 4'b0, 32'hFFFF_80F0));
    vecs.push_back(mk(K_STORE, 0, 1, 3'b001, 32'h30, 32'h1111_BEEF, 4'b0011, 32'h0));
    vecs.push_back(mk(K_LOAD,  1, 0, 3'b010, 32'h30, 32'h0, 4'b0, 32'h0000_BEEF));
    vecs.push_back(mk(K_LOAD,  1, 0, 3'b000, 32'h31, 32'h0, 4'b0, 32'hFFFF_FFBE));
    vecs.push_back(mk(K_LOAD,  1, 0, 3'b100, 32'h21, 32'h0, 4'b0, 32'h0000_0012));
    vecs.push_back(mk(K_FAULT, 1, 0, 3'b011, 32'h20, 32'h0, 4'b0, 32'h0));
    vecs.push_back(mk(K_FAULT, 0, 1, 3'b100, 32'h40, 32'h5555_5555, 4'b0, 32'h0));
    vecs.push_back(mk(K_FAULT, 1, 1, 3'b010, 32'h20, 32'h0, 4'b0, 32'h0));
    vecs.push_back(mk(K_NOP,   0, 0, 3'b010, 32'h20, 32'h0, 4'b0, 32'h0));
`ifdef LSU_MISALIGN_TRAP_EN
    vecs.push_back(mk(K_FAULT, 1, 0, 3'b010, 32'h21, 32'h0, 4'b0, 32'h0));
`else
    vecs.push_back(mk(K_LOAD,  1, 0, 3'b010, 32'h21, 32'h0, 4'b0, 32'h0080_F012));
`endif

    // Reset state, with a store presented while rst is high.
    rst = 1'b1;
    req_valid = 1'b0; req_is_load = 1'b0; req_is_store = 1'b0;
    req_funct3 = 3'b000; req_addr = '0; req_store_data = '0;
    drive_req(0, 1, 3'b010, 32'h44, 32'h1234_5678);
    @(negedge clk);
    check("reset write_enable", mem_write_enable, 0);
    check("reset mem_address", mem_address, 0);
    check("reset stall", stall, 0);
    check("reset load_data", load_data, 0);
    check("reset load_data_valid", load_data_valid, 0);
    check("reset access_fault", access_fault, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    foreach (vecs[i]) do_req(vecs[i]);

    // Slow memory: five read_enable cycles before the ack.
    ack_delay = 5;
    drive_req(1, 0, 3'b010, 32'h20, 32'h0);
    @(negedge clk);
    check("slow accept stall", stall, 1);
    sb.push_back('{fault: 1'b0, data: 32'h80F0_1234});
    saw = 1'b0;
    for (lat = 1; lat <= 100; lat++) begin
      @(negedge clk);
      if (load_data_valid) break;
      check("slow stall", stall, 1);
      check("slow mem_address", mem_address, 32'h20);
      if (mem_read_valid) begin
        check("slow read_enable in ack cycle", mem_read_enable, 0);
        saw = 1'b1;
      end else begin
        check("slow read_enable", mem_read_enable, !saw);
      end
    end
    check("slow ack seen", saw, 1);
    check("slow load latency", lat, 8);
    idle(2);

    // Reset while in RD_WAIT, then a stale acknowledge.
    ack_delay = 1000;
    drive_req(1, 0, 3'b010, 32'h20, 32'h0);
    @(negedge clk);
    check("rstwait accept stall", stall, 1);
    @(negedge clk);
    check("rstwait read_enable", mem_read_enable, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    req_valid = 1'b0; req_is_load = 1'b0;
    @(negedge clk);
    check("rstwait stall", stall, 0);
    check("rstwait read_enable off", mem_read_enable, 0);
    check("rstwait mem_address", mem_address, 0);
    check("rstwait load_data", load_data, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    inject_ack = 1'b1;
    @(posedge clk);
    #1;
    inject_ack = 1'b0;
    saw = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (mem_read_valid) saw = 1'b1;
      check("stale ack load_data_valid", load_data_valid, 0);
      check("stale ack stall", stall, 0);
      check("stale ack read_enable", mem_read_enable, 0);
    end
    check("stale ack was driven", saw, 1);
    check("stale ack load_data", load_data, 0);

    idle(3);
    check("scoreboard drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
